peripheral_wb_burst_master: RTL and testbench
=============================================

// Module: peripheral_wb_burst_master
// PURPOSE
//  Per-core Wishbone B3 burst master sitting directly upstream of one port of the multi-port SPRAM.
//  Turns a single-beat or cache-line request from a core into a classic cycle or a wrapping incrementing burst.
//  Drives CTI/BTE/address sequencing; streams write data in and read data out.
// PARAMETERS
//  AW       8   byte-address width (matches SPRAM DEPTH=256)
//  DW       32  data width; fixed 32, so one beat = 4 bytes
//  TIMEOUT  64  cycles without ack/err before abort (used only with the macro below)
// PORTS
//  wb_clk_i      in   1     clock
//  wb_rst_i      in   1     asynchronous, active-low reset
//  req_valid_i   in   1     request valid
//  req_ready_o   out  1     request accepted when valid&ready; high only in IDLE
//  req_we_i      in   1     1=write, 0=read
//  req_adr_i     in   AW    byte address of the first (critical) word
//  req_len_i     in   2     0=single, 1=wrap4, 2=wrap8, 3=wrap16 (equals the BTE encoding)
//  req_sel_i     in   4     byte select, applied to every beat
//  wdat_i        in   DW    current write beat; must be valid while the master is in BUS state
//  wdat_next_o   out  1     pulse: write beat consumed, present the next one
//  rdat_o        out  DW    read beat (wb_dat_i registered)
//  rdat_valid_o  out  1     pulse per read beat
//  done_o        out  1     1-cycle pulse at end of request
//  err_o         out  1     qualifies done_o; 1 = terminated by error or timeout
//  wb_adr_o wb_dat_o wb_sel_o wb_we_o wb_bte_o[2] wb_cti_o[3] wb_cyc_o wb_stb_o   out  Wishbone master signals
//  wb_ack_i wb_err_i wb_dat_i                                                      in   Wishbone slave response
// BEHAVIOUR
//  FSM states:
//   IDLE: req_ready_o=1; on accept, latch we/adr/len/sel -> BUS
//   BUS: cyc=stb=1; one beat per cycle with wb_ack_i
//   On the last ack or on wb_err_i -> DONE
//   DONE: cyc=stb=0; done_o=1 for 1 cycle -> IDLE
//  Latency: accept at cycle N; cyc/stb rise at N+1; first address = req_adr_i with bits [1:0] forced to 0.
//  Beats: 1/4/8/16 for len 0/1/2/3.
//   Beat counter is 4 bits and advances on each ack.
//   The last beat is the one whose ack arrives with counter = beats-1.
//  CTI:
//   len=0 -> 000 (classic)
//   otherwise 010 on every beat except the last, which is 111
//  BTE = latched len.
//  Address on ack: word index wraps within the aligned block.
//   len1: adr[3:2]+1; len2: adr[4:2]+1; len3: adr[5:2]+1
//   Upper bits are unchanged.
//   Example: 0x0C wrap4 -> 0x0C,0x00,0x04,0x08
//  Ack handling: without ack, all outputs hold stable (slave wait states allowed; ack gaps allowed).
//  Write: wb_dat_o = wdat_i (combinational); wdat_next_o = wb_ack_i & we & BUS.
//  Read: on ack, rdat_o <= wb_dat_i and rdat_valid_o <= 1 (1 cycle later).
//  Error: wb_err_i in BUS ends the burst that cycle.
//   No further beats; err_o=1 alongside done_o.
//   err has priority over a simultaneous ack; that beat is not counted or delivered.
//  done_o follows the last ack by 1 cycle; cyc drops the cycle after the last ack.
//  Requests are not accepted in BUS or DONE; back-to-back requests have at least 1 idle cycle (DONE).
//  Reset: async assert forces IDLE immediately, mid-burst included.
//   All outputs 0 except req_ready_o, which is 1 after reset.
//   Counters and latched fields are cleared.
// CONFIGURATION
//  WB_BURST_MASTER_TIMEOUT_EN defined:
//   A counter clears on entering BUS and on each ack.
//   If it reaches TIMEOUT-1 in BUS -> abort to DONE with err_o=1.
//  Macro undefined: no counter; the master waits indefinitely for ack/err.
// TESTING
//  1. Single write adr=0x10, sel=0xF, wdat=0xDEADBEEF, ack 1 cycle after stb
//     -> cti=000, bte=00, one wdat_next_o pulse, done_o=1, err_o=0.
//  2. Wrap4 read adr=0x0C, slave acks every cycle
//     -> adr 0C,00,04,08; cti 010,010,010,111; 4 rdat_valid_o pulses in order; done_o next cycle.
//  3. Wrap16 write adr=0x24, ack deasserted on beats 3 and 9 for 2 cycles each
//     -> adr/dat/cti held during gaps; 16 wdat_next_o pulses; adr sequence 24..3C,00..20.
//  4. Wrap8 read, wb_err_i on beat 5 together with ack
//     -> 4 rdat_valid_o pulses only; cyc low next cycle; done_o=1, err_o=1.
//  5. Reset asserted mid wrap8 burst (beat 3)
//     -> cyc/stb/done_o low asynchronously; req_ready_o=1 after release; new single read completes normally.
//  6. (WB_BURST_MASTER_TIMEOUT_EN, TIMEOUT=64) slave never acks
//     -> cyc drops after 64 BUS cycles; done_o=1, err_o=1.

Source files
------------

// File: rtl/peripheral_wb_burst_master.sv
// Wishbone B3 burst master: single-beat or wrapping cache-line bursts toward one SPRAM port.
// Optional slave-response timeout enabled by defining WB_BURST_MASTER_TIMEOUT_EN.
module peripheral_wb_burst_master #(
  parameter int unsigned AW      = 8,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic          req_we_i,
  input  logic [AW-1:0] req_adr_i,
  input  logic [1:0]    req_len_i,
  input  logic [3:0]    req_sel_i,
  input  logic [DW-1:0] wdat_i,
  output logic          wdat_next_o,
  output logic [DW-1:0] rdat_o,
  output logic          rdat_valid_o,
  output logic          done_o,
  output logic          err_o,
  output logic [AW-1:0] wb_adr_o,
  output logic [DW-1:0] wb_dat_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic [1:0]    wb_bte_o,
  output logic [2:0]    wb_cti_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic [DW-1:0] wb_dat_i
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    last_cnt;
  logic [AW-1:0] blk_mask;
  logic [AW-1:0] adr_inc, adr_next;
  logic          timeout_hit;

  logic          ready_d, done_d, err_d, rvalid_d, cyc_d, stb_d, we_d;
  logic [DW-1:0] rdat_d;
  logic [AW-1:0] adr_d;
  logic [3:0]    sel_d;
  logic [1:0]    bte_d;
  logic [2:0]    cti_d;

  // Burst length and wrap block size follow the latched BTE (== request length).
  always_comb begin
    last_cnt = 4'd0;
    blk_mask = AW'(32'h3);
    case (wb_bte_o)
      2'd1:    begin last_cnt = 4'd3;  blk_mask = AW'(32'hF);  end
      2'd2:    begin last_cnt = 4'd7;  blk_mask = AW'(32'h1F); end
      2'd3:    begin last_cnt = 4'd15; blk_mask = AW'(32'h3F); end
      default: begin last_cnt = 4'd0;  blk_mask = AW'(32'h3);  end
    endcase
  end

  // Word index wraps inside the aligned block; bits above the block stay put.
  assign adr_inc  = wb_adr_o + AW'(4);
  assign adr_next = (wb_adr_o & ~blk_mask) | (adr_inc & blk_mask);

`ifdef WB_BURST_MASTER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT) + 1;
  logic [TW-1:0] tmo_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      tmo_q <= '0;
    end else if (state_q != ST_BUS || wb_ack_i) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + TW'(1);
    end
  end

  assign timeout_hit = (state_q == ST_BUS) && !wb_ack_i && (tmo_q == TW'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
`endif

  assign wb_dat_o    = wdat_i;
  assign wdat_next_o = wb_ack_i & wb_we_o & (state_q == ST_BUS);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ready_d  = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    rvalid_d = 1'b0;
    rdat_d   = rdat_o;
    cyc_d    = wb_cyc_o;
    stb_d    = wb_stb_o;
    we_d     = wb_we_o;
    adr_d    = wb_adr_o;
    sel_d    = wb_sel_o;
    bte_d    = wb_bte_o;
    cti_d    = wb_cti_o;
    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (req_valid_i && req_ready_o) begin
          state_d = ST_BUS;
          ready_d = 1'b0;
          cnt_d   = 4'd0;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = req_we_i;
          adr_d   = req_adr_i & ~AW'(32'h3);
          sel_d   = req_sel_i;
          bte_d   = req_len_i;
          cti_d   = (req_len_i == 2'd0) ? CTI_CLASSIC : CTI_INC;
        end
      end
      ST_BUS: begin
        // Error wins over a simultaneous ack; that beat is dropped.
        if (wb_err_i || timeout_hit) begin
          state_d = ST_DONE;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (wb_ack_i) begin
          if (!wb_we_o) begin
            rdat_d   = wb_dat_i;
            rvalid_d = 1'b1;
          end
          if (cnt_q == last_cnt) begin
            state_d = ST_DONE;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
            adr_d = adr_next;
            cti_d = ((cnt_q + 4'd1) == last_cnt) ? CTI_END : CTI_INC;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      req_ready_o  <= 1'b1;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      rdat_valid_o <= 1'b0;
      rdat_o       <= '0;
      wb_cyc_o     <= 1'b0;
      wb_stb_o     <= 1'b0;
      wb_we_o      <= 1'b0;
      wb_adr_o     <= '0;
      wb_sel_o     <= '0;
      wb_bte_o     <= '0;
      wb_cti_o     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_o  <= ready_d;
      done_o       <= done_d;
      err_o        <= err_d;
      rdat_valid_o <= rvalid_d;
      rdat_o       <= rdat_d;
      wb_cyc_o     <= cyc_d;
      wb_stb_o     <= stb_d;
      wb_we_o      <= we_d;
      wb_adr_o     <= adr_d;
      wb_sel_o     <= sel_d;
      wb_bte_o     <= bte_d;
      wb_cti_o     <= cti_d;
    end
  end

endmodule

// File: tb/tb_peripheral_wb_burst_master.sv
// Bench for peripheral_wb_burst_master: directed vector table, reset/timeout sequences and
// randomized bursts checked against an arithmetic model of the wrap/CTI rules.
module tb_peripheral_wb_burst_master;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned TIMEOUT = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_adr;
  logic [1:0]    req_len;
  logic [3:0]    req_sel;
  logic [DW-1:0] wdat, rdat;
  logic          wdat_next, rdat_valid, done, err;
  logic [AW-1:0] wb_adr;
  logic [DW-1:0] wb_dat_o, wb_dat_i;
  logic [3:0]    wb_sel;
  logic          wb_we, wb_cyc, wb_stb, wb_ack, wb_err;
  logic [1:0]    wb_bte;
  logic [2:0]    wb_cti;

  always #5 clk = ~clk;

  peripheral_wb_burst_master #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_adr_i(req_adr), .req_len_i(req_len), .req_sel_i(req_sel),
    .wdat_i(wdat), .wdat_next_o(wdat_next), .rdat_o(rdat), .rdat_valid_o(rdat_valid),
    .done_o(done), .err_o(err),
    .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel), .wb_we_o(wb_we),
    .wb_bte_o(wb_bte), .wb_cti_o(wb_cti), .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb),
    .wb_ack_i(wb_ack), .wb_err_i(wb_err), .wb_dat_i(wb_dat_i)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] mem [64];

  typedef struct {
    logic        we;
    logic [7:0]  adr;
    logic [1:0]  len;
    logic [3:0]  sel;
    logic [31:0] w0;
    logic [15:0] stall_mask;
    int          stall_len;
    int          err_beat;
    int          exp_beats;
    logic [7:0]  exp_last_adr;
    logic        exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic int beats_of(input logic [1:0] len);
    return (len == 2'd0) ? 1 : (1 << (int'(len) + 1));
  endfunction

  // Address of beat k: critical word first, word index wrapping inside a 4*beats byte block.
  function automatic logic [7:0] model_adr(input logic [7:0] adr, input logic [1:0] len, input int k);
    int blk, a;
    blk = 4 * beats_of(len);
    a   = int'({24'd0, adr}) & ~3;
    return 8'((a - (a % blk)) + ((a % blk) + 4 * k) % blk);
  endfunction

  function automatic logic [2:0] model_cti(input logic [1:0] len, input int k);
    if (len == 2'd0) return 3'b000;
    return (k == beats_of(len) - 1) ? 3'b111 : 3'b010;
  endfunction

  // Issues one request and plays a Wishbone slave backed by mem[], checking every cycle.
  task automatic run_txn(input string tag, input vec_t v);
    int beats, k, acked, guard, stall_left;
    logic ended, a_c, e_c;
    logic [7:0]  exp_a, last_adr;
    logic [31:0] rexp;
    logic [21:0] bus_act, bus_exp;
    beats = beats_of(v.len);
    k = 0; acked = 0; guard = 0; ended = 1'b0; last_adr = 8'h00; rexp = 32'h0;
    @(negedge clk);
    check({tag, ".ready"}, 32'(req_ready), 32'(1));
    req_valid = 1'b1; req_we = v.we; req_adr = v.adr; req_len = v.len; req_sel = v.sel;
    @(negedge clk);
    req_valid = 1'b0;
    stall_left = v.stall_mask[0] ? v.stall_len : 0;
    while (!ended && guard < 400) begin
      guard++;
      exp_a   = model_adr(v.adr, v.len, k);
      bus_exp = {1'b1, 1'b1, 1'b0, 1'b0, v.we, v.len, model_cti(v.len, k), v.sel, exp_a};
      bus_act = {wb_cyc, wb_stb, done, req_ready, wb_we, wb_bte, wb_cti, wb_sel, wb_adr};
      check($sformatf("%s.bus[%0d]", tag, k), 32'(bus_act), 32'(bus_exp));
      wdat     = v.w0 + 32'(k) * 32'h01010101;
      wb_dat_i = mem[wb_adr[7:2]];
      rexp     = mem[exp_a[7:2]];
      if (stall_left > 0) begin
        a_c = 1'b0; e_c = 1'b0; stall_left--;
      end else begin
        a_c = 1'b1; e_c = (k == v.err_beat);
      end
      wb_ack = a_c; wb_err = e_c;
      #1;
      check($sformatf("%s.wdat_next[%0d]", tag, k), 32'(wdat_next), 32'(a_c & v.we));
      if (v.we) check($sformatf("%s.wb_dat[%0d]", tag, k), wb_dat_o, wdat);
      if (a_c && !e_c && v.we)
        for (int b = 0; b < 4; b++)
          if (wb_sel[b]) mem[wb_adr[7:2]][8*b +: 8] = wb_dat_o[8*b +: 8];
      @(negedge clk);
      wb_ack = 1'b0; wb_err = 1'b0;
      check($sformatf("%s.rvalid[%0d]", tag, k), 32'(rdat_valid), 32'(a_c & ~e_c & ~v.we));
      if (a_c && !e_c && !v.we) check($sformatf("%s.rdat[%0d]", tag, k), rdat, rexp);
      if (e_c) begin
        ended = 1'b1; last_adr = exp_a;
      end else if (a_c) begin
        acked++;
        if (k == beats - 1) begin
          ended = 1'b1; last_adr = exp_a;
        end else begin
          k++;
          stall_left = v.stall_mask[k] ? v.stall_len : 0;
        end
      end
    end
    check({tag, ".ended"}, 32'(ended), 32'(1));
    check({tag, ".done"}, 32'({wb_cyc, wb_stb, done, err, req_ready}), 32'({3'b001, v.exp_err, 1'b0}));
    check({tag, ".beats"}, 32'(acked), 32'(v.exp_beats));
    check({tag, ".last_adr"}, 32'(last_adr), 32'(v.exp_last_adr));
    @(negedge clk);
    check({tag, ".idle"}, 32'({wb_cyc, done, err, req_ready}), 32'(4'b0001));
  endtask

  vec_t vecs [9];
  vec_t rv;
  int   cyc_cnt;

  initial begin
    //        we    adr    len  sel   w0            stall   sl  err beats last   err
    vecs[0] = '{1'b1, 8'h10, 2'd0, 4'hF, 32'hDEADBEEF, 16'h0001, 1, -1, 1,  8'h10, 1'b0};
    vecs[1] = '{1'b0, 8'h0C, 2'd1, 4'hF, 32'h0,        16'h0000, 0, -1, 4,  8'h08, 1'b0};
    vecs[2] = '{1'b1, 8'h24, 2'd3, 4'hF, 32'h10203040, 16'h0104, 2, -1, 16, 8'h20, 1'b0};
    vecs[3] = '{1'b0, 8'h14, 2'd2, 4'hF, 32'h0,        16'h0000, 0,  4, 4,  8'h04, 1'b1};
    vecs[4] = '{1'b0, 8'h0E, 2'd0, 4'h3, 32'h0,        16'h0000, 0, -1, 1,  8'h0C, 1'b0};
    vecs[5] = '{1'b1, 8'hF8, 2'd2, 4'h5, 32'hA5A5A5A5, 16'h00AA, 1, -1, 8,  8'hF4, 1'b0};
    vecs[6] = '{1'b0, 8'h24, 2'd3, 4'hF, 32'h0,        16'h0000, 0, -1, 16, 8'h20, 1'b0};
    vecs[7] = '{1'b0, 8'h30, 2'd1, 4'hF, 32'h0,        16'h0000, 0,  0, 0,  8'h30, 1'b1};
    vecs[8] = '{1'b1, 8'h3A, 2'd1, 4'hC, 32'h55667788, 16'h0008, 1,  3, 3,  8'h34, 1'b1};

    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_len = '0; req_sel = '0;
    wdat = '0; wb_ack = 1'b0; wb_err = 1'b0; wb_dat_i = '0;
    #12;
    check("reset.ctrl", 32'({req_ready, wb_cyc, wb_stb, done, err, rdat_valid, wb_we, wdat_next}), 32'(8'h80));
    check("reset.bus", 32'({wb_adr, wb_sel, wb_bte, wb_cti}), 32'(0));
    check("reset.rdat", rdat, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_txn($sformatf("vec%0d", i), vecs[i]);

    // Asynchronous reset in the fourth beat of a wrap8 read.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_adr = 8'h40; req_len = 2'd2; req_sel = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wb_ack = 1'b1; wb_dat_i = mem[wb_adr[7:2]];
      @(negedge clk);
    end
    wb_ack = 1'b0;
    check("rst_mid.in_burst", 32'({wb_cyc, wb_stb, wb_adr}), 32'({2'b11, 8'h4C}));
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid.async", 32'({wb_cyc, wb_stb, done, req_ready, rdat_valid}), 32'(5'b00010));
    check("rst_mid.adr", 32'(wb_adr), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    rv = '{1'b0, 8'h44, 2'd0, 4'hF, 32'h0, 16'h0000, 0, -1, 1, 8'h44, 1'b0};
    run_txn("after_rst", rv);

`ifdef WB_BURST_MASTER_TIMEOUT_EN
    // Slave never answers: master must abort after TIMEOUT bus cycles.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_adr = 8'h08; req_len = 2'd0; req_sel = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    cyc_cnt = 0;
    while (wb_cyc && cyc_cnt < 200) begin
      cyc_cnt++;
      @(negedge clk);
    end
    check("timeout.cycles", 32'(cyc_cnt), 32'(TIMEOUT));
    check("timeout.done", 32'({done, err}), 32'(2'b11));
    @(negedge clk);
`else
    // Without the timeout the master waits through a long stall.
    cyc_cnt = 0;
    rv = '{1'b0, 8'h18, 2'd0, 4'hF, 32'h0, 16'h0001, 100, -1, 1, 8'h18, 1'b0};
    run_txn("long_stall", rv);
`endif

    // Randomized bursts with random stalls and occasional errors.
    for (int i = 0; i < 40; i++) begin
      rv.we         = 1'($urandom);
      rv.adr        = 8'($urandom);
      rv.len        = 2'($urandom);
      rv.sel        = 4'($urandom);
      rv.w0         = $urandom;
      rv.stall_mask = 16'($urandom);
      rv.stall_len  = int'($urandom_range(1, 3));
      rv.err_beat   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, beats_of(rv.len) - 1)) : -1;
      rv.exp_err    = (rv.err_beat >= 0);
      rv.exp_beats  = rv.exp_err ? rv.err_beat : beats_of(rv.len);
      rv.exp_last_adr = model_adr(rv.adr, rv.len, rv.exp_err ? rv.err_beat : beats_of(rv.len) - 1);
      run_txn($sformatf("rnd%0d", i), rv);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
